wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage directly downstream of the ALU execute stage; also consumes load results from the LSU.
- Arbitrates register-file writes: the ALU has fixed priority, and LSU results are buffered in a small FIFO.
- Issues the global redirect `wb_do_branch`/`wb_branch_target`, branch-predictor updates, and the fence.i I$ invalidation handshake.

Parameters:
- LSU_FIFO_DEPTH, 2, LSU result buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result valid
- alu_wb_inf  in  alu_wb_inf_t  {do_branch, branch_target[31:0], control_flow_pc[31:0], icache_invalidate, register_write, rd[4:0], exe_result[31:0]}
- lsu_valid  in  1  load result valid
- lsu_rd  in  5  load destination
- lsu_result  in  32  load data
- lsu_ready  out  1  FIFO not full; LSU transfers when lsu_valid && lsu_ready
- rf_we  out  1  register file write enable
- rf_rd  out  5  write address
- rf_wdata  out  32  write data
- wb_do_branch  out  1  one-cycle redirect pulse to fetch/IX/ALU
- wb_branch_target  out  32  redirect PC
- btp_update_valid  out  1  predictor update strobe
- btp_update_pc  out  32  control_flow_pc passthrough, bit0 = direction encoding
- btp_update_target  out  32  resolved target
- icache_inv_req  out  1  I$ invalidate request
- icache_inv_ack  in  1  I$ invalidate done
- wb_hold  out  1  high while an invalidation is outstanding

Behaviour:
- Reset: every output 0; FIFO empty; FSM in IDLE; `lsu_ready` is 1 in the first cycle after reset release.
- All outputs are registered. Latency from input to `rf_we`/`wb_do_branch`/`btp_update_valid` is 1 cycle.
- `alu_accept` = `alu_valid` && state==IDLE.
- RF arbitration, per cycle:
  - If `alu_accept` && `register_write` && rd≠0: write `exe_result`.
  - Otherwise, if the FIFO is non-empty: pop the head and write it, unless its rd==0, in which case pop and discard.
  - The ALU never stalls. An LSU result waits at most as long as back-to-back ALU writes continue.
- FIFO:
  - Push on `lsu_valid` && `lsu_ready`.
  - Simultaneous push and pop when full: `lsu_ready` uses full-before-pop, so there is no push that cycle.
  - Push and pop on the same entry when count==1 is legal; the count is unchanged.
  - Pointers wrap modulo LSU_FIFO_DEPTH.
  - The FIFO is never flushed by `wb_do_branch`, because loads are older than the redirect.
- Redirect, in IDLE:
  - Condition: `alu_accept` && `do_branch` && !`icache_invalidate`.
  - Next cycle: `wb_do_branch`=1, `wb_branch_target`=`branch_target`, `btp_update_valid`=1, `btp_update_pc`=`control_flow_pc`, `btp_update_target`=`branch_target`.
  - The RF write for that instruction (jal/jalr link) still occurs in the same cycle.
- FSM states and transitions:
  - IDLE → INV_WAIT on `alu_accept` && `icache_invalidate`.
    - On this transition, capture `branch_target` (PC+4) into `inv_target` and perform the instruction's RF write if any.
    - The next cycle, assert `icache_inv_req`=1 and `wb_hold`=1.
  - INV_WAIT: hold `icache_inv_req` until `icache_inv_ack`.
    - ALU inputs are discarded: no RF write, no redirect, no predictor update.
    - The FIFO keeps draining.
  - INV_WAIT → IDLE on `icache_inv_ack`. The next cycle: `icache_inv_req`=0, `wb_hold`=0, `wb_do_branch`=1, `wb_branch_target`=`inv_target`, `btp_update_valid`=0.
  - `icache_inv_ack` in IDLE is ignored.
- `wb_do_branch` is never high for two consecutive cycles.
- Reset mid-INV_WAIT: return to IDLE with all outputs dropped immediately (asynchronous).

Decomposition:
- Shared package (defines):
  - `lsu_wb_inf_t` {rd, result}.
  - `wb_state_t` enum {WB_IDLE, WB_INV_WAIT}.
  - `alu_wb_inf_t` already lives there.
- Sub-module `wb_lsu_fifo` (synchronous FIFO, parameterised depth/width, async active-high reset):
  - Ports: clk, rst, push, push_data, pop, pop_data, full, empty.
- Arbitration, FSM and output registers live in `wb_stage`.

Test Plan:
- ALU alone:
  - Stimulus: `alu_valid`=1, rd=5, `exe_result`=0x1234, `register_write`=1.
  - Response: next cycle `rf_we`=1, `rf_rd`=5, `rf_wdata`=0x1234, `wb_do_branch`=0.
- Collision:
  - Stimulus: same cycle LSU pushes rd=7/0xCAFE and ALU writes rd=3/0x11, then ALU idle.
  - Response: cycle+1 writes rd3=0x11; cycle+2 writes rd7=0xCAFE.
- Backpressure:
  - Stimulus: 4 LSU pushes while the ALU writes every cycle.
  - Response: `lsu_ready` deasserts after 2 accepted pushes; entries later drain in order with no loss or duplication.
- Mispredict:
  - Stimulus: `do_branch`=1, `branch_target`=0x400, `control_flow_pc`=0x101, rd=1, `exe_result`=0x10C.
  - Response: next cycle `wb_do_branch`=1, target=0x400, `btp_update_pc`=0x101, `rf_we` rd1=0x10C; the following cycle `wb_do_branch`=0.
- fence.i:
  - Stimulus: `icache_invalidate`=1 with `branch_target`=0x208; ALU valid results for 3 cycles; `icache_inv_ack` 5 cycles later.
  - Response: `icache_inv_req`/`wb_hold` high, the 3 results produce no `rf_we`, then a single `wb_do_branch` to 0x208 with `btp_update_valid`=0.
- Async reset:
  - Stimulus: assert `rst` mid-INV_WAIT with the FIFO holding 2 entries.
  - Response: all outputs 0 immediately, and no `rf_we` after release until new input arrives.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared writeback-stage types
package wb_stage_pkg;
  typedef struct packed {
    logic        do_branch;
    logic [31:0] branch_target;
    logic [31:0] control_flow_pc;
    logic        icache_invalidate;
    logic        register_write;
    logic [4:0]  rd;
    logic [31:0] exe_result;
  } alu_wb_inf_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
  } lsu_wb_inf_t;
  typedef enum logic {WB_IDLE, WB_INV_WAIT} wb_state_t;
  localparam int LSU_WB_W = $bits(lsu_wb_inf_t);
endpackage

// File: rtl/wb_lsu_fifo.sv
// wb_lsu_fifo: small synchronous FIFO buffering load results
module wb_lsu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push_ok, pop_ok;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign pop_data = mem[rp];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  // storage needs no reset; validity is tracked by cnt
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= push_data;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback arbitration, redirect and fence.i invalidation handshake
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  alu_wb_inf_t alu_wb_inf,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_result,
  output logic        lsu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        wb_do_branch,
  output logic [31:0] wb_branch_target,
  output logic        btp_update_valid,
  output logic [31:0] btp_update_pc,
  output logic [31:0] btp_update_target,
  output logic        icache_inv_req,
  input  logic        icache_inv_ack,
  output logic        wb_hold
);
  wb_state_t state, state_next;
  lsu_wb_inf_t head;
  logic full, empty, alu_accept, alu_wr, pop, push, redirect, inv_start, inv_done;
  logic [31:0] inv_target;
  assign alu_accept = alu_valid && state == WB_IDLE;
  assign alu_wr = alu_accept && alu_wb_inf.register_write && alu_wb_inf.rd != 5'd0;
  assign pop = !alu_wr && !empty;
  assign lsu_ready = !full && !rst;
  assign push = lsu_valid && lsu_ready;
  assign inv_start = alu_accept && alu_wb_inf.icache_invalidate;
  assign inv_done = state == WB_INV_WAIT && icache_inv_ack;
  // a redirect in flight flushes the ALU, so a following branch cannot fire back-to-back
  assign redirect = alu_accept && alu_wb_inf.do_branch && !alu_wb_inf.icache_invalidate && !wb_do_branch;
  wb_lsu_fifo #(.DEPTH(LSU_FIFO_DEPTH), .WIDTH(LSU_WB_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .push_data({lsu_rd, lsu_result}),
    .pop(pop), .pop_data(head), .full(full), .empty(empty)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= WB_IDLE;
    else state <= state_next;
  // next state: enter on fence.i, leave on invalidate ack
  always_comb begin
    state_next = state;
    state_next = inv_start ? WB_INV_WAIT : inv_done ? WB_IDLE : state;
  end
  // registered outputs and fence.i return target
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wdata <= '0;
      wb_do_branch <= 1'b0;
      wb_branch_target <= '0;
      btp_update_valid <= 1'b0;
      btp_update_pc <= '0;
      btp_update_target <= '0;
      icache_inv_req <= 1'b0;
      wb_hold <= 1'b0;
      inv_target <= '0;
    end else begin
      rf_we <= alu_wr || (pop && head.rd != 5'd0);
      rf_rd <= alu_wr ? alu_wb_inf.rd : head.rd;
      rf_wdata <= alu_wr ? alu_wb_inf.exe_result : head.result;
      wb_do_branch <= redirect || inv_done;
      if (redirect || inv_done) wb_branch_target <= inv_done ? inv_target : alu_wb_inf.branch_target;
      btp_update_valid <= redirect;
      if (redirect) btp_update_pc <= alu_wb_inf.control_flow_pc;
      if (redirect) btp_update_target <= alu_wb_inf.branch_target;
      icache_inv_req <= state_next == WB_INV_WAIT;
      wb_hold <= state_next == WB_INV_WAIT;
      if (inv_start) inv_target <= alu_wb_inf.branch_target;
    end
endmodule
